reaction_ctrl: RTL and testbench

Trial sequencer for the reaction-time detector. It consumes the square-wave timebase produced by the clock divider (one time unit per rising edge) and runs the full measurement. Each trial goes through these steps: arm on start, wait a pseudo-random delay, light the GO lamp, count time units until the player reacts, then publish the result. It sits between the debounced buttons, the divider output and the display/score logic.

---
 rtl/reaction_pkg.sv | 25 ++
 rtl/reaction_ctrl_edge_sync.sv | 27 ++
 rtl/reaction_ctrl.sv | 150 +++++++++++++++
 tb/tb_reaction_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and defaults for the reaction-time trial sequencer.
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_GO,
        S_DONE,
        S_FOUL
    } state_t;

    localparam int unsigned DEF_CNT_W     = 14;
    localparam int unsigned DEF_MAX_TIME  = 9999;
    localparam int unsigned DEF_DELAY_MIN = 100;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1, shifting toward the MSB
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'h01;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_ctrl_edge_sync.sv
// Input synchroniser with registered rising-edge pulse (two-cycle input-to-pulse latency).
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_sync;
    logic r_sync_d;
    logic r_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_sync   <= i_d;
            r_sync_d <= r_sync;
            r_rise   <= r_sync & ~r_sync_d;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time trial sequencer: arm, random wait, GO, measure, publish.
// Optional best-time tracking is enabled with `define REACTION_BEST_EN.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned MAX_TIME  = DEF_MAX_TIME,
    parameter int unsigned DELAY_MIN = DEF_DELAY_MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             react,
    output logic             led_go,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             false_start,
    output logic             timeout
`ifdef REACTION_BEST_EN
    ,
    output logic [CNT_W-1:0] best_time
`endif
);

    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(MAX_TIME);
    localparam logic [CNT_W-1:0] LP_DMIN = CNT_W'(DELAY_MIN);

    logic w_tick, w_start, w_react;

    state_t r_state, w_state_nxt;
    logic   w_react_done, w_time_done;
    logic   w_led_go_nxt, w_busy_nxt, w_false_nxt;

    logic [7:0]       r_lfsr;
    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_elapsed;
    logic [CNT_W-1:0] r_result;
    logic             r_valid;
    logic             r_timeout;
    logic             r_led_go, r_busy, r_false;

    edge_sync u_sync_tick  (.clk(clk), .rst(rst), .i_d(tick),  .o_rise(w_tick));
    edge_sync u_sync_start (.clk(clk), .rst(rst), .i_d(start), .o_rise(w_start));
    edge_sync u_sync_react (.clk(clk), .rst(rst), .i_d(react), .o_rise(w_react));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_led_go <= 1'b0;
            r_busy   <= 1'b0;
            r_false  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_led_go <= w_led_go_nxt;
            r_busy   <= w_busy_nxt;
            r_false  <= w_false_nxt;
        end
    end

    // react takes priority over a coincident tick in both WAIT and GO
    always_comb begin
        w_state_nxt  = r_state;
        w_react_done = 1'b0;
        w_time_done  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_FOUL: if (w_start) w_state_nxt = S_ARM;
            S_ARM:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_react)
                    w_state_nxt = S_FOUL;
                else if (w_tick && r_delay <= CNT_W'(1))
                    w_state_nxt = S_GO;
            end
            S_GO: begin
                if (w_react) begin
                    w_state_nxt  = S_DONE;
                    w_react_done = 1'b1;
                end else if (w_tick && r_elapsed >= LP_MAX - CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                    w_time_done = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_led_go_nxt = (w_state_nxt == S_GO);
        w_busy_nxt   = (w_state_nxt == S_ARM) || (w_state_nxt == S_WAIT) ||
                       (w_state_nxt == S_GO);
        w_false_nxt  = (w_state_nxt == S_FOUL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr    <= LFSR_SEED;
            r_delay   <= '0;
            r_elapsed <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_lfsr  <= lfsr_step(r_lfsr);
            r_valid <= w_react_done | w_time_done;

            if (r_state == S_ARM)
                r_delay <= LP_DMIN + CNT_W'(r_lfsr);
            else if (r_state == S_WAIT && w_tick && !w_react && r_delay != '0)
                r_delay <= r_delay - CNT_W'(1);

            if (r_state == S_WAIT)
                r_elapsed <= '0;
            else if (r_state == S_GO && w_tick && !w_react && r_elapsed < LP_MAX)
                r_elapsed <= r_elapsed + CNT_W'(1);

            if (w_react_done)
                r_result <= r_elapsed;
            else if (w_time_done)
                r_result <= LP_MAX;

            if (w_time_done)
                r_timeout <= 1'b1;
            else if (w_state_nxt == S_ARM)
                r_timeout <= 1'b0;
        end
    end

`ifdef REACTION_BEST_EN
    logic [CNT_W-1:0] r_best;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_best <= '1;
        else if (w_react_done && r_elapsed < r_best)
            r_best <= r_elapsed;
    end

    assign best_time = r_best;
`endif

    assign led_go       = r_led_go;
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_valid;
    assign false_start  = r_false;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl: table-driven trials, corner sequences, random trials.
module tb_reaction_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        react = 1'b0;
    logic        led_go, busy, result_valid, false_start, timeout;
    logic [13:0] result;
`ifdef REACTION_BEST_EN
    logic [13:0] best_time;
`endif

    reaction_ctrl #(
        .CNT_W     (14),
        .MAX_TIME  (9999),
        .DELAY_MIN (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .start        (start),
        .react        (react),
        .led_go       (led_go),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .false_start  (false_start),
        .timeout      (timeout)
`ifdef REACTION_BEST_EN
        ,
        .best_time    (best_time)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int rv_count = 0;
    int exp_result = 0;
    int exp_best = 16383;

    // reference pseudo-random source: x^8+x^6+x^5+x^4+1, seed 1, one step per clock
    logic [7:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 8'h01;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    always @(negedge clk) if (result_valid === 1'b1) rv_count++;

    typedef struct {
        int n;
        bit foul;
        int foul_after;
        int exp_res;
        bit exp_fs;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse_tick();
    endtask

    task automatic arm(output int delay);
        int i;
        start = 1'b1;
        i = 0;
        while (busy !== 1'b1 && i < 10) begin
            @(negedge clk);
            i++;
        end
        chk("arm_busy", busy, 1);
        chk("arm_fs_clear", false_start, 0);
        chk("arm_to_clear", timeout, 0);
        chk("arm_result_held", result, exp_result);
        delay = 100 + int'(m_lfsr);
        start = 1'b0;
    endtask

    task automatic go_wait(input int delay);
        ticks(delay - 1);
        nclk(2);
        chk("pre_go_led", led_go, 0);
        chk("pre_go_busy", busy, 1);
        pulse_tick();
        nclk(2);
        chk("go_led", led_go, 1);
    endtask

    task automatic run_trial(input int n, input bit foul, input int foul_after,
                             input int exp_res, input bit exp_fs);
        int d;
        int rv0;
        rv0 = rv_count;
        arm(d);
        if (foul) begin
            ticks(foul_after);
            react = 1'b1;
            nclk(4);
            react = 1'b0;
            nclk(2);
            chk("foul_rv", rv_count - rv0, 0);
            chk("foul_led", led_go, 0);
            chk("foul_busy", busy, 0);
        end else begin
            go_wait(d);
            ticks(n);
            react = 1'b1;
            nclk(4);
            chk("trial_rv", rv_count - rv0, 1);
            chk("trial_led", led_go, 0);
            chk("trial_busy", busy, 0);
            chk("trial_to", timeout, 0);
            react = 1'b0;
            nclk(2);
            if (n < exp_best) exp_best = n;
        end
        chk("trial_result", result, exp_res);
        chk("trial_fs", false_start, exp_fs);
        exp_result = exp_res;
`ifdef REACTION_BEST_EN
        chk("trial_best", best_time, exp_best);
`endif
    endtask

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int rv0;
        int rn, rfa;
        bit rfoul;

        vecs[0] = '{n: 250, foul: 1'b0, foul_after: 0,  exp_res: 250, exp_fs: 1'b0};
        vecs[1] = '{n: 180, foul: 1'b0, foul_after: 0,  exp_res: 180, exp_fs: 1'b0};
        vecs[2] = '{n: 300, foul: 1'b0, foul_after: 0,  exp_res: 300, exp_fs: 1'b0};
        vecs[3] = '{n: 37,  foul: 1'b0, foul_after: 0,  exp_res: 37,  exp_fs: 1'b0};
        vecs[4] = '{n: 0,   foul: 1'b1, foul_after: 10, exp_res: 37,  exp_fs: 1'b1};
        vecs[5] = '{n: 0,   foul: 1'b0, foul_after: 0,  exp_res: 0,   exp_fs: 1'b0};
        vecs[6] = '{n: 0,   foul: 1'b1, foul_after: 0,  exp_res: 0,   exp_fs: 1'b1};
        vecs[7] = '{n: 5,   foul: 1'b0, foul_after: 0,  exp_res: 5,   exp_fs: 1'b0};

        #2 rst = 1'b1;
        nclk(3);
        chk("rst_led", led_go, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_fs", false_start, 0);
        chk("rst_to", timeout, 0);
`ifdef REACTION_BEST_EN
        chk("rst_best", best_time, 16383);
`endif
        rst = 1'b0;
        nclk(2);

        for (int i = 0; i < 3; i++)
            run_trial(vecs[i].n, vecs[i].foul, vecs[i].foul_after, vecs[i].exp_res, vecs[i].exp_fs);
`ifdef REACTION_BEST_EN
        chk("best_after_three", best_time, 180);
`endif

        // timeout trial
        rv0 = rv_count;
        arm(d);
        go_wait(d);
        ticks(9998);
        nclk(2);
        chk("to_pre_busy", busy, 1);
        chk("to_pre_flag", timeout, 0);
        pulse_tick();
        nclk(2);
        chk("to_result", result, 9999);
        chk("to_flag", timeout, 1);
        chk("to_rv", rv_count - rv0, 1);
        chk("to_led", led_go, 0);
        chk("to_busy", busy, 0);
        exp_result = 9999;
`ifdef REACTION_BEST_EN
        chk("to_best", best_time, 180);
`endif

        for (int i = 3; i < 8; i++)
            run_trial(vecs[i].n, vecs[i].foul, vecs[i].foul_after, vecs[i].exp_res, vecs[i].exp_fs);

        // react edge coincident with tick #20 captures the pre-increment count
        arm(d);
        go_wait(d);
        ticks(19);
        tick = 1'b1;
        react = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        nclk(3);
        chk("simul_result", result, 19);
        chk("simul_led", led_go, 0);
        react = 1'b0;
        nclk(2);
        exp_result = 19;

        // start presses during WAIT must not restart the delay
        arm(d);
        ticks(20);
        start = 1'b1;
        nclk(4);
        chk("wait_start_busy", busy, 1);
        chk("wait_start_led", led_go, 0);
        start = 1'b0;
        nclk(1);
        go_wait(d - 20);
        ticks(3);
        react = 1'b1;
        nclk(4);
        chk("wait_start_result", result, 3);
        react = 1'b0;
        nclk(2);
        exp_result = 3;
        if (exp_best > 3) exp_best = 3;

        for (int k = 0; k < 6; k++) begin
            rfoul = ($urandom_range(0, 3) == 0);
            rn    = $urandom_range(0, 80);
            rfa   = $urandom_range(0, 60);
            run_trial(rn, rfoul, rfa, rfoul ? exp_result : rn, rfoul);
        end

        // asynchronous reset in the middle of GO
        arm(d);
        go_wait(d);
        ticks(5);
        #1 rst = 1'b1;
        #1;
        chk("arst_led", led_go, 0);
        chk("arst_busy", busy, 0);
        chk("arst_result", result, 0);
        chk("arst_rv", result_valid, 0);
        chk("arst_fs", false_start, 0);
        chk("arst_to", timeout, 0);
`ifdef REACTION_BEST_EN
        chk("arst_best", best_time, 16383);
`endif
        @(negedge clk);
        rst = 1'b0;
        nclk(3);
        chk("post_rst_busy", busy, 0);
        exp_result = 0;
        exp_best = 16383;
        run_trial(12, 1'b0, 0, 12, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
